// File: rtl/perceptron_ctrl.sv
// perceptron_ctrl
//   Byte-level command sequencer between a UART byte interface and the
//   perceptron datapath. Decodes host frames, loads weights/bias, streams input
//   vectors, waits for the classification result and returns it (or ACK/NAK).
//
//   Frames (first byte = opcode):
//     01 w0..w(N-1) -> weight writes, reply ACK
//     02 b          -> bias write, reply ACK
//     03 x0..x(N-1) -> input stream, reply with datapath result
//     other         -> reply NAK
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     rx_data/rx_valid         received byte + one-cycle strobe
//     tx_data/tx_valid/tx_ready outgoing byte, held until accepted
//     dp_w_*                   weight write port (strobe, index, data)
//     dp_b_*                   bias write port
//     dp_x_*                   input element stream (strobe, index, data, last)
//     dp_res/dp_res_valid      datapath result + one-cycle strobe
//     busy                     high whenever not idle
//     err_drop                 one-cycle pulse when a received byte is discarded
module perceptron_ctrl #(
    parameter int         N       = 4,
    parameter int         IDX_W   = 2,
    parameter int         TIMEOUT = 1000000,
    parameter logic [7:0] ACK     = 8'hAA,
    parameter logic [7:0] NAK     = 8'hEE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             dp_w_we,
    output logic [IDX_W-1:0] dp_w_addr,
    output logic [7:0]       dp_w_data,
    output logic             dp_b_we,
    output logic [7:0]       dp_b_data,
    output logic             dp_x_valid,
    output logic [IDX_W-1:0] dp_x_idx,
    output logic [7:0]       dp_x_data,
    output logic             dp_x_last,
    input  logic [7:0]       dp_res,
    input  logic             dp_res_valid,
    output logic             busy,
    output logic             err_drop
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, W_LOAD, B_LOAD, X_LOAD, WAIT_RES, SEND} state_t;

    state_t         state;
    logic [IDX_W:0] cnt;
    logic [TW-1:0]  tmo;
    logic           tmo_hit;
    logic           cnt_last;

    assign tmo_hit  = (tmo == TW'(TIMEOUT - 1));
    assign cnt_last = (cnt == (IDX_W + 1)'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            tmo        <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            dp_w_we    <= 1'b0;
            dp_w_addr  <= '0;
            dp_w_data  <= '0;
            dp_b_we    <= 1'b0;
            dp_b_data  <= '0;
            dp_x_valid <= 1'b0;
            dp_x_idx   <= '0;
            dp_x_data  <= '0;
            dp_x_last  <= 1'b0;
            busy       <= 1'b0;
            err_drop   <= 1'b0;
        end else begin
            // strobes are single-cycle by default
            dp_w_we    <= 1'b0;
            dp_b_we    <= 1'b0;
            dp_x_valid <= 1'b0;
            dp_x_last  <= 1'b0;
            err_drop   <= 1'b0;

            case (state)
                IDLE: begin
                    tmo <= '0;
                    if (rx_valid) begin
                        cnt  <= '0;
                        busy <= 1'b1;
                        case (rx_data)
                            8'h01:   state <= W_LOAD;
                            8'h02:   state <= B_LOAD;
                            8'h03:   state <= X_LOAD;
                            default: begin
                                state    <= SEND;
                                tx_data  <= NAK;
                                tx_valid <= 1'b1;
                            end
                        endcase
                    end
                end

                W_LOAD: begin
                    if (rx_valid) begin
                        tmo       <= '0;
                        dp_w_we   <= 1'b1;
                        dp_w_addr <= cnt[IDX_W-1:0];
                        dp_w_data <= rx_data;
                        cnt       <= cnt + 1'b1;
                        // ACK goes out alongside the final weight write
                        if (cnt_last) begin
                            state    <= SEND;
                            tx_data  <= ACK;
                            tx_valid <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        tmo      <= '0;
                        state    <= SEND;
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                B_LOAD: begin
                    if (rx_valid) begin
                        tmo       <= '0;
                        dp_b_we   <= 1'b1;
                        dp_b_data <= rx_data;
                        state     <= SEND;
                        tx_data   <= ACK;
                        tx_valid  <= 1'b1;
                    end else if (tmo_hit) begin
                        tmo      <= '0;
                        state    <= SEND;
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                X_LOAD: begin
                    if (rx_valid) begin
                        tmo        <= '0;
                        dp_x_valid <= 1'b1;
                        dp_x_idx   <= cnt[IDX_W-1:0];
                        dp_x_data  <= rx_data;
                        dp_x_last  <= cnt_last;
                        cnt        <= cnt + 1'b1;
                        if (cnt_last)
                            state <= WAIT_RES;
                    end else if (tmo_hit) begin
                        tmo      <= '0;
                        state    <= SEND;
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                WAIT_RES: begin
                    if (rx_valid)
                        err_drop <= 1'b1;
                    // a result arriving on the expiry cycle still wins
                    if (dp_res_valid) begin
                        tmo      <= '0;
                        state    <= SEND;
                        tx_data  <= dp_res;
                        tx_valid <= 1'b1;
                    end else if (tmo_hit) begin
                        tmo      <= '0;
                        state    <= SEND;
                        tx_data  <= NAK;
                        tx_valid <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                SEND: begin
                    tmo <= '0;
                    if (rx_valid)
                        err_drop <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_ctrl.sv
// tb_perceptron_ctrl
//   Randomized + directed bench for perceptron_ctrl. A frame-level model pushes
//   the expected datapath writes, tx bytes and drop pulses into queues; an
//   independent monitor pops and compares whenever the DUT presents them.
module tb_perceptron_ctrl;

    localparam int N   = 4;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       dp_w_we;
    logic [1:0] dp_w_addr;
    logic [7:0] dp_w_data;
    logic       dp_b_we;
    logic [7:0] dp_b_data;
    logic       dp_x_valid;
    logic [1:0] dp_x_idx;
    logic [7:0] dp_x_data;
    logic       dp_x_last;
    logic [7:0] dp_res = 8'h00;
    logic       dp_res_valid = 1'b0;
    logic       busy;
    logic       err_drop;

    always #5 clk = ~clk;

    perceptron_ctrl #(.N(N), .IDX_W(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .dp_w_we(dp_w_we), .dp_w_addr(dp_w_addr), .dp_w_data(dp_w_data),
        .dp_b_we(dp_b_we), .dp_b_data(dp_b_data),
        .dp_x_valid(dp_x_valid), .dp_x_idx(dp_x_idx), .dp_x_data(dp_x_data),
        .dp_x_last(dp_x_last),
        .dp_res(dp_res), .dp_res_valid(dp_res_valid),
        .busy(busy), .err_drop(err_drop)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    longint      cyc    = 0;
    longint      last_rx_cyc = 0;
    logic [7:0]  tx_q[$];
    logic [9:0]  w_q[$];     // {addr, data}
    logic [7:0]  b_q[$];
    logic [10:0] x_q[$];     // {last, idx, data}
    int          exp_drops = 0;
    bit          hold_low  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic unexpected(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event seen, none expected", nm);
    endtask

    // tx_ready: mostly high, randomly stalled, or forced low
    initial forever begin
        @(posedge clk); #1;
        tx_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // scoreboard monitor, sampling mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (dp_w_we) begin
                if (w_q.size() == 0) unexpected("w_write");
                else begin
                    check("w_write", {dp_w_addr, dp_w_data}, w_q.pop_front());
                    if (dp_w_addr == 2'(N - 1)) check("ack_with_last_w", tx_valid, 1'b1);
                end
            end
            if (dp_b_we) begin
                if (b_q.size() == 0) unexpected("b_write");
                else check("b_write", dp_b_data, b_q.pop_front());
            end
            if (dp_x_valid) begin
                if (x_q.size() == 0) unexpected("x_elem");
                else check("x_elem", {dp_x_last, dp_x_idx, dp_x_data}, x_q.pop_front());
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) unexpected("tx_byte");
                else check("tx_byte", tx_data, tx_q.pop_front());
            end
            if (err_drop) begin
                if (exp_drops == 0) unexpected("err_drop");
                else exp_drops--;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        last_rx_cyc = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_res(input logic [7:0] r);
        dp_res       = r;
        dp_res_valid = 1'b1;
        tick();
        dp_res_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 5000) begin tick(); k++; end
        check("idle_within_budget", busy, 1'b0);
        tick();
    endtask

    // reference model: expectations derived from the frame contents alone
    task automatic do_frame(input logic [7:0] op, input logic [N*8-1:0] pl,
                            input logic [7:0] res, input int res_dly);
        int nb;
        nb = 0;
        case (op)
            8'h01: begin
                for (int i = 0; i < N; i++) w_q.push_back({2'(i), pl[i*8 +: 8]});
                tx_q.push_back(8'hAA);
                nb = N;
            end
            8'h02: begin
                b_q.push_back(pl[7:0]);
                tx_q.push_back(8'hAA);
                nb = 1;
            end
            8'h03: begin
                for (int i = 0; i < N; i++) x_q.push_back({(i == N - 1), 2'(i), pl[i*8 +: 8]});
                tx_q.push_back(res);
                nb = N;
            end
            default: tx_q.push_back(8'hEE);
        endcase
        send_byte(op);
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(pl[i*8 +: 8]);
        end
        if (op == 8'h03) begin
            repeat (res_dly) tick();
            pulse_res(res);
        end
        wait_idle();
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {tx_valid, tx_data, dp_w_we, dp_w_addr, dp_w_data, dp_b_we, dp_b_data,
                   dp_x_valid, dp_x_idx, dp_x_data, dp_x_last, busy, err_drop}, 64'd0);
    endtask

    initial begin
        logic [7:0]     op;
        logic [N*8-1:0] pl;
        int             k;
        int             bad;

        repeat (3) tick();
        check_all_zero("reset_outputs");
        rst = 1'b0;
        tick();

        // weight load
        do_frame(8'h01, {8'h40, 8'h30, 8'h20, 8'h10}, 8'h00, 0);
        check("busy_after_wload", busy, 1'b0);

        // bias load, then a run with a late result
        do_frame(8'h02, {24'h0, 8'hF6}, 8'h00, 0);
        do_frame(8'h03, {8'h04, 8'h03, 8'h02, 8'h01}, 8'h5A, 10);

        // bad opcode under backpressure; a byte arriving during SEND is dropped
        hold_low = 1'b1;
        tick(); tick();
        tx_q.push_back(8'hEE);
        send_byte(8'h7F);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) begin exp_drops++; send_byte(8'h01); end
            else tick();
            if (!(tx_valid === 1'b1 && tx_data === 8'hEE)) bad++;
        end
        check("nak_held_under_backpressure", bad, 0);
        check("drop_in_send_seen", exp_drops, 0);
        hold_low = 1'b0;
        wait_idle();

        // timeout mid weight frame, NAK exactly TMO cycles after last byte
        w_q.push_back({2'd0, 8'h11});
        tx_q.push_back(8'hEE);
        send_byte(8'h01);
        send_byte(8'h11);
        k = 0;
        while (!tx_valid && k < 2000) begin tick(); k++; end
        check("timeout_latency", cyc - last_rx_cyc, TMO);
        wait_idle();
        do_frame(8'h01, {8'h04, 8'h03, 8'h02, 8'h01}, 8'h00, 0);

        // drop during WAIT_RES
        for (int i = 0; i < N; i++) x_q.push_back({(i == N - 1), 2'(i), 8'(8'hA0 + i)});
        tx_q.push_back(8'h3C);
        send_byte(8'h03);
        for (int i = 0; i < N; i++) send_byte(8'(8'hA0 + i));
        tick(); tick();
        exp_drops++;
        send_byte(8'h55);
        tick(); tick();
        check("drop_in_wait_seen", exp_drops, 0);
        pulse_res(8'h3C);
        wait_idle();

        // reset mid-frame: no reply, next frame restarts at index 0
        x_q.push_back({1'b0, 2'd0, 8'h01});
        x_q.push_back({1'b0, 2'd1, 8'h02});
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h02);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("mid_frame_reset_outputs");
        check("x_q_after_reset", x_q.size(), 0);
        repeat (5) tick();
        check("no_tx_after_reset", tx_valid, 1'b0);
        do_frame(8'h03, {8'h08, 8'h07, 8'h06, 8'h05}, 8'h77, 3);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 3))
                0: op = 8'h01;
                1: op = 8'h02;
                2: op = 8'h03;
                default: begin
                    op = 8'($urandom_range(4, 255));
                    if ($urandom_range(0, 7) == 0) op = 8'h00;
                end
            endcase
            pl = {$urandom, $urandom} >> (64 - N*8);
            do_frame(op, pl, 8'($urandom), $urandom_range(0, 15));
        end

        repeat (5) tick();
        check("tx_q_drained", tx_q.size(), 0);
        check("w_q_drained", w_q.size(), 0);
        check("b_q_drained", b_q.size(), 0);
        check("x_q_drained", x_q.size(), 0);
        check("drops_drained", exp_drops, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
